// File: rtl/cmacc_pkg.sv
// Shared types, latency constant and saturation helper for the framed complex MAC.
package cmacc_pkg;

    localparam int unsigned CMACC_LAT = 5;
    localparam int unsigned SAT_MAXW  = 64;

    typedef struct packed {
        logic valid;
        logic first;
        logic last;
    } cmacc_tag_t;

    // Clamp a wide signed value into a w-bit signed range (w <= SAT_MAXW).
    function automatic logic signed [SAT_MAXW-1:0] cmacc_sat(
        input logic signed [SAT_MAXW:0] v,
        input int unsigned              w
    );
        logic signed [SAT_MAXW:0] one;
        logic signed [SAT_MAXW:0] hi;
        logic signed [SAT_MAXW:0] lo;
        one    = '0;
        one[0] = 1'b1;
        hi     = (one <<< (w - 1)) - one;
        lo     = -hi - one;
        if (v > hi) begin
            return hi[SAT_MAXW-1:0];
        end else if (v < lo) begin
            return lo[SAT_MAXW-1:0];
        end
        return v[SAT_MAXW-1:0];
    endfunction

endpackage

// File: rtl/cmult3.sv
// Four-stage 3-multiplier complex product (optionally by conj(b)) with tag passthrough.
module cmult3
    import cmacc_pkg::*;
#(
    parameter int unsigned AWIDTH  = 16,
    parameter int unsigned BWIDTH  = 18,
    parameter int unsigned SIZEOUT = 40
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  cmacc_tag_t                tag_i,
    input  logic                      conj_i,
    input  logic signed [AWIDTH-1:0]  ar_i,
    input  logic signed [AWIDTH-1:0]  ai_i,
    input  logic signed [BWIDTH-1:0]  br_i,
    input  logic signed [BWIDTH-1:0]  bi_i,
    output cmacc_tag_t                tag_o,
    output logic signed [SIZEOUT-1:0] pr_o,
    output logic signed [SIZEOUT-1:0] pi_o
);

    localparam int unsigned BNW = BWIDTH + 1;
    localparam int unsigned PW  = AWIDTH + BWIDTH + 2;

    cmacc_tag_t tag1_q, tag2_q, tag3_q, tag4_q;

    logic signed [AWIDTH-1:0]  ar1_q, ai1_q, ar2_q, ai2_q;
    logic signed [BWIDTH-1:0]  br1_q, bi1_q;
    logic                      conj1_q;
    logic signed [BNW-1:0]     bn_d, bn2_q;
    logic signed [AWIDTH:0]    ad2_q;
    logic signed [BWIDTH+1:0]  bs2_q, bp2_q;
    logic signed [PW-1:0]      mc3_q, mr3_q, mi3_q;
    logic signed [SIZEOUT-1:0] pr4_q, pi4_q;

    // One extra bit so negating the most negative bi cannot overflow.
    always_comb begin
        bn_d = BNW'(bi1_q);
        if (conj1_q) begin
            bn_d = -bn_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tag1_q <= '0;
            tag2_q <= '0;
            tag3_q <= '0;
            tag4_q <= '0;
        end else begin
            tag1_q <= tag_i;
            tag2_q <= tag1_q;
            tag3_q <= tag2_q;
            tag4_q <= tag3_q;
        end
    end

    always_ff @(posedge clk_i) begin
        ar1_q   <= ar_i;
        ai1_q   <= ai_i;
        br1_q   <= br_i;
        bi1_q   <= bi_i;
        conj1_q <= conj_i;

        ar2_q   <= ar1_q;
        ai2_q   <= ai1_q;
        bn2_q   <= bn_d;
        ad2_q   <= (AWIDTH+1)'(ar1_q) - (AWIDTH+1)'(ai1_q);
        bs2_q   <= (BWIDTH+2)'(br1_q) - (BWIDTH+2)'(bn_d);
        bp2_q   <= (BWIDTH+2)'(br1_q) + (BWIDTH+2)'(bn_d);

        mc3_q   <= PW'(bn2_q) * PW'(ad2_q);
        mr3_q   <= PW'(ar2_q) * PW'(bs2_q);
        mi3_q   <= PW'(ai2_q) * PW'(bp2_q);

        pr4_q   <= SIZEOUT'(mr3_q) + SIZEOUT'(mc3_q);
        pi4_q   <= SIZEOUT'(mi3_q) + SIZEOUT'(mc3_q);
    end

    assign tag_o = tag4_q;
    assign pr_o  = pr4_q;
    assign pi_o  = pi4_q;

endmodule

// File: rtl/cmacc_frame.sv
// Framed complex multiply-accumulate: frame counter, cmult3 product pipe and S5 accumulator.
// Define CMACC_SAT_EN for saturating accumulation with a per-frame sticky overflow flag.
module cmacc_frame
    import cmacc_pkg::*;
#(
    parameter int unsigned AWIDTH  = 16,
    parameter int unsigned BWIDTH  = 18,
    parameter int unsigned SIZEOUT = 40,
    parameter int unsigned LENW    = 16
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [LENW-1:0]           acc_len_i,
    input  logic                      in_valid_i,
    input  logic                      conj_i,
    input  logic signed [AWIDTH-1:0]  ar_i,
    input  logic signed [AWIDTH-1:0]  ai_i,
    input  logic signed [BWIDTH-1:0]  br_i,
    input  logic signed [BWIDTH-1:0]  bi_i,
    output logic                      out_valid_o,
    output logic signed [SIZEOUT-1:0] pr_o,
    output logic signed [SIZEOUT-1:0] pi_o,
    output logic                      out_ovf_o,
    output logic                      frame_active_o
);

`ifdef CMACC_SAT_EN
    localparam int unsigned SW = SIZEOUT + 1;
`else
    localparam int unsigned SW = SIZEOUT;
`endif

    logic [LENW-1:0] cnt_q, cnt_d, len_q, len_d, len_cur;
    logic            first_in, last_in;
    cmacc_tag_t      tag_in, p_tag;

    logic signed [SIZEOUT-1:0] p_re, p_im;
    logic signed [SIZEOUT-1:0] acc_re_q, acc_im_q, acc_re_d, acc_im_d;
    logic signed [SIZEOUT-1:0] pr_q, pi_q;
    logic signed [SW-1:0]      sum_re, sum_im;
    logic                      out_valid_q;

    // Frame length is taken from acc_len only on the first accepted sample.
    always_comb begin
        first_in = (cnt_q == '0);
        len_cur  = len_q;
        if (first_in) begin
            len_cur = (acc_len_i == '0) ? LENW'(1) : acc_len_i;
        end
        last_in = (cnt_q == len_cur - LENW'(1));
        cnt_d   = cnt_q;
        len_d   = len_q;
        if (in_valid_i) begin
            cnt_d = last_in ? '0 : cnt_q + LENW'(1);
            if (first_in) begin
                len_d = len_cur;
            end
        end
    end

    assign tag_in = '{valid: in_valid_i, first: first_in, last: last_in};

    cmult3 #(
        .AWIDTH (AWIDTH),
        .BWIDTH (BWIDTH),
        .SIZEOUT(SIZEOUT)
    ) u_cmult3 (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .tag_i (tag_in),
        .conj_i(conj_i),
        .ar_i  (ar_i),
        .ai_i  (ai_i),
        .br_i  (br_i),
        .bi_i  (bi_i),
        .tag_o (p_tag),
        .pr_o  (p_re),
        .pi_o  (p_im)
    );

`ifdef CMACC_SAT_EN
    logic step_ovf, frame_ovf, ovf_q, out_ovf_q;
`endif

    always_comb begin
        sum_re = SW'(acc_re_q) + SW'(p_re);
        sum_im = SW'(acc_im_q) + SW'(p_im);
`ifdef CMACC_SAT_EN
        acc_re_d  = SIZEOUT'(cmacc_sat((SAT_MAXW+1)'(sum_re), SIZEOUT));
        acc_im_d  = SIZEOUT'(cmacc_sat((SAT_MAXW+1)'(sum_im), SIZEOUT));
        step_ovf  = (sum_re[SW-1] ^ sum_re[SW-2]) | (sum_im[SW-1] ^ sum_im[SW-2]);
        frame_ovf = p_tag.first ? 1'b0 : (ovf_q | step_ovf);
`else
        acc_re_d = sum_re;
        acc_im_d = sum_im;
`endif
        if (p_tag.first) begin
            acc_re_d = p_re;
            acc_im_d = p_im;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q       <= '0;
            len_q       <= '0;
            acc_re_q    <= '0;
            acc_im_q    <= '0;
            pr_q        <= '0;
            pi_q        <= '0;
            out_valid_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            len_q       <= len_d;
            out_valid_q <= p_tag.valid & p_tag.last;
            if (p_tag.valid) begin
                acc_re_q <= acc_re_d;
                acc_im_q <= acc_im_d;
                if (p_tag.last) begin
                    pr_q <= acc_re_d;
                    pi_q <= acc_im_d;
                end
            end
        end
    end

`ifdef CMACC_SAT_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ovf_q     <= 1'b0;
            out_ovf_q <= 1'b0;
        end else begin
            out_ovf_q <= p_tag.valid & p_tag.last & frame_ovf;
            if (p_tag.valid) begin
                ovf_q <= p_tag.last ? 1'b0 : frame_ovf;
            end
        end
    end
    assign out_ovf_o = out_ovf_q;
`else
    assign out_ovf_o = 1'b0;
`endif

    assign out_valid_o    = out_valid_q;
    assign pr_o           = pr_q;
    assign pi_o           = pi_q;
    assign frame_active_o = (cnt_q != '0);

endmodule

// File: tb/tb_cmacc_frame.sv
// Scoreboard bench for cmacc_frame: complex-arithmetic reference model, decoupled output monitor.
module tb_cmacc_frame;

    localparam int unsigned AW = 16;
    localparam int unsigned BW = 18;
    localparam int unsigned SO = 36;
    localparam int unsigned LW = 16;
    localparam int          PERIOD = 10;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [LW-1:0]        acc_len = '0;
    logic                 in_valid = 1'b0;
    logic                 conj = 1'b0;
    logic signed [AW-1:0] ar = '0, ai = '0;
    logic signed [BW-1:0] br = '0, bi = '0;
    logic                 out_valid, out_ovf, frame_active;
    logic signed [SO-1:0] pr, pi;

    always #(PERIOD/2) clk = ~clk;

    cmacc_frame #(
        .AWIDTH (AW),
        .BWIDTH (BW),
        .SIZEOUT(SO),
        .LENW   (LW)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .acc_len_i     (acc_len),
        .in_valid_i    (in_valid),
        .conj_i        (conj),
        .ar_i          (ar),
        .ai_i          (ai),
        .br_i          (br),
        .bi_i          (bi),
        .out_valid_o   (out_valid),
        .pr_o          (pr),
        .pi_o          (pi),
        .out_ovf_o     (out_ovf),
        .frame_active_o(frame_active)
    );

    typedef struct {
        longint re;
        longint im;
        bit     ovf;
        longint t;
    } exp_t;

    exp_t   sb[$];
    int     n_checks = 0;
    int     n_pass = 0;
    longint hold_re = 0, hold_im = 0;

    // Reference model state: samples accepted so far in the open frame and running sums.
    int     m_cnt = 0, m_len = 1;
    longint m_re = 0, m_im = 0;
    bit     m_ovf = 0;

    task automatic check(input bit ok, input string name, input longint act, input longint req);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    endtask

    function automatic longint fit(input longint v, output bit o);
        longint hi, lo;
        hi = (longint'(1) <<< (SO - 1)) - 1;
        lo = -hi - 1;
        o  = 0;
`ifdef CMACC_SAT_EN
        if (v > hi) begin o = 1; return hi; end
        if (v < lo) begin o = 1; return lo; end
        return v;
`else
        return (v <<< (64 - SO)) >>> (64 - SO);
`endif
    endfunction

    task automatic model_accept(input int a_r, input int a_i, input int b_r, input int b_i,
                                input bit cj, input int len);
        longint bim, p_re, p_im;
        bit o1, o2;
        bim  = cj ? -longint'(b_i) : longint'(b_i);
        p_re = longint'(a_r) * longint'(b_r) - longint'(a_i) * bim;
        p_im = longint'(a_r) * bim + longint'(a_i) * longint'(b_r);
        if (m_cnt == 0) begin
            m_len = (len == 0) ? 1 : len;
            m_re  = p_re;
            m_im  = p_im;
            m_ovf = 0;
        end else begin
            m_re  = fit(m_re + p_re, o1);
            m_im  = fit(m_im + p_im, o2);
            m_ovf = m_ovf | o1 | o2;
        end
        m_cnt++;
        if (m_cnt == m_len) begin
            // Result expected five cycles after accept, sampled on the falling edge.
            sb.push_back('{re: m_re, im: m_im, ovf: m_ovf, t: $time + 4*PERIOD + PERIOD/2});
            m_cnt = 0;
        end
    endtask

    task automatic drive(input bit v, input int a_r, input int a_i, input int b_r, input int b_i,
                         input bit cj, input int len);
        @(negedge clk);
        in_valid = v;
        ar       = AW'(a_r);
        ai       = AW'(a_i);
        br       = BW'(b_r);
        bi       = BW'(b_i);
        conj     = cj;
        acc_len  = LW'(len);
        @(posedge clk);
        if (v) model_accept(a_r, a_i, b_r, b_i, cj, len);
        #1;
        check(frame_active == (m_cnt != 0), "frame_active", frame_active, m_cnt != 0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 1);
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 20) begin
            idle(1);
            n++;
        end
        check(sb.size() == 0, "drain_timeout", sb.size(), 0);
        idle(2);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst      = 1'b1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        m_cnt   = 0;
        hold_re = 0;
        hold_im = 0;
        rst     = 1'b0;
        check(out_valid == 1'b0, "rst_out_valid", out_valid, 0);
        check(pr == '0, "rst_pr", longint'(pr), 0);
        check(pi == '0, "rst_pi", longint'(pi), 0);
        check(out_ovf == 1'b0, "rst_out_ovf", out_ovf, 0);
        check(frame_active == 1'b0, "rst_frame_active", frame_active, 0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) continue;
            if (out_valid) begin
                if (sb.size() == 0) begin
                    check(0, "unexpected_pulse", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check(longint'(pr) == e.re, "pr", longint'(pr), e.re);
                    check(longint'(pi) == e.im, "pi", longint'(pi), e.im);
                    check(out_ovf == e.ovf, "out_ovf", out_ovf, e.ovf);
                    check(longint'($time) == e.t, "latency", longint'($time), e.t);
                    hold_re = e.re;
                    hold_im = e.im;
                end
            end else begin
                check(out_ovf == 1'b0, "ovf_idle", out_ovf, 0);
                check(longint'(pr) == hold_re && longint'(pi) == hold_im, "hold_pr",
                      longint'(pr), hold_re);
            end
        end
    end

    initial begin : watchdog
        #(200000 * PERIOD);
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        do_reset();

        // Single-sample frames, plain and conjugate.
        drive(1, 3, 4, 5, -2, 0, 1);
        drive(1, 3, 4, 5, -2, 1, 1);
        drain();

        // Four-sample frame with bubbles between samples.
        for (int i = 0; i < 4; i++) begin
            drive(1, 1, 1, 1, 1, 0, 4);
            drive(0, 0, 0, 0, 0, 0, 4);
        end
        drain();

        // Back-to-back pairs.
        for (int k = 1; k <= 6; k++) drive(1, 1, 0, k, 0, 0, 2);
        drain();

        // acc_len of zero behaves as one.
        for (int k = 0; k < 3; k++) drive(1, k + 2, -k, 7, k - 5, k % 2, 0);
        drain();

        // Reset mid-frame discards the partial frame.
        drive(1, 9, 9, 9, 9, 0, 4);
        drive(1, 9, 9, 9, 9, 0, 4);
        do_reset();
        for (int k = 0; k < 4; k++) drive(1, 1, 0, 1, 0, 0, 4);
        drain();

        // Accumulator range boundary: 8 * 2^32 reaches 2^35.
        for (int k = 0; k < 8; k++) drive(1, -32768, 0, -131072, 0, 0, 8);
        drive(1, 2, 1, 3, 1, 0, 1);
        drain();

        // Random traffic with bubbles, random conj and acc_len changing every cycle.
        for (int n = 0; n < 400; n++) begin
            drive($urandom_range(0, 9) < 7,
                  int'($urandom_range(0, 65535)) - 32768,
                  int'($urandom_range(0, 65535)) - 32768,
                  int'($urandom_range(0, 262143)) - 131072,
                  int'($urandom_range(0, 262143)) - 131072,
                  $urandom_range(0, 1) == 1,
                  int'($urandom_range(0, 6)));
        end
        // Close any open frame so its result is checked too.
        while (m_cnt != 0) drive(1, 5, -3, 7, 11, 0, 1);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
